// File: rtl/controller_sequencer.sv
// Ring-counter control unit for the 4-bit CPU: steps T1..T6 (or HALT) and decodes
// the phase plus the IR opcode into the 13-bit datapath control word.
module controller_sequencer (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    output logic [12:0] ctrl,
    output logic [5:0]  t_state,
    output logic        halted
);

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd6
    } state_t;

    // The single bus driver for the current phase; decoding it to one-hot enables
    // makes two simultaneous drivers impossible.
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PC,
        SRC_RAM,
        SRC_IR,
        SRC_ACC,
        SRC_ALU
    } src_t;

    // Field order matches the control-word bit map, cp in the MSB.
    typedef struct packed {
        logic cp;
        logic ep;
        logic lp;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t state;
    state_t state_next;
    src_t   src;
    ctrl_t  strobes;
    ctrl_t  word;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= T1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next = state;
        if (run) begin
            case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                T3:      state_next = T4;
                T4:      state_next = (opcode == OP_HLT) ? HALT : T5;
                T5:      state_next = T6;
                T6:      state_next = T1;
                HALT:    state_next = HALT;
                default: state_next = T1;
            endcase
        end
    end

    // Phase/opcode decode: bus source and load/operation strobes kept separate.
    always_comb begin
        src     = SRC_NONE;
        strobes = '0;
        case (state)
            T1: begin
                src        = SRC_PC;
                strobes.lm = 1'b1;
            end
            T2: strobes.cp = 1'b1;
            T3: begin
                src        = SRC_RAM;
                strobes.li = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        src        = SRC_IR;
                        strobes.lm = 1'b1;
                    end
                    OP_JMP: begin
                        src        = SRC_IR;
                        strobes.lp = 1'b1;
                    end
                    OP_OUT: begin
                        src        = SRC_ACC;
                        strobes.lo = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        src        = SRC_RAM;
                        strobes.la = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        src        = SRC_RAM;
                        strobes.lb = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    src        = SRC_ALU;
                    strobes.la = 1'b1;
                    strobes.su = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        word    = strobes;
        word.ep = (src == SRC_PC);
        word.ce = (src == SRC_RAM);
        word.ei = (src == SRC_IR);
        word.ea = (src == SRC_ACC);
        word.eu = (src == SRC_ALU);
        if (!run || state == HALT) begin
            word = '0;
        end
    end

    assign ctrl = word;

    always_comb begin
        t_state = '0;
        case (state)
            T1:      t_state = 6'b000001;
            T2:      t_state = 6'b000010;
            T3:      t_state = 6'b000100;
            T4:      t_state = 6'b001000;
            T5:      t_state = 6'b010000;
            T6:      t_state = 6'b100000;
            default: t_state = '0;
        endcase
    end

    assign halted = (state == HALT);

endmodule
